// File: rtl/fc_weight_ctrl.sv
// Weight-buffer sequencer for the FC layer: clears and fills the 128-column weight
// buffer row by row, then replays rows 0..L-1 into the skewed column read chain.
module fc_weight_ctrl #(
    parameter int DEPTH = 84,
    parameter int COLS  = 128,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] cfg_len_i,
    input  logic          load_start_i,
    input  logic          compute_start_i,
    input  logic          abort_i,
    input  logic          w_valid_i,
    output logic          w_ready_o,
    output logic          buf_wren_o,
    output logic [AW-1:0] buf_wrptr_o,
    output logic          buf_rden_o,
    output logic [AW-1:0] buf_rdptr_o,
    output logic          buf_clr_n_o,
    output logic          col0_valid_o,
    output logic          busy_o,
    output logic          loaded_o,
    output logic          load_done_o,
    output logic          compute_done_o,
    output logic          err_o
);

    localparam int CW = $clog2(COLS);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, READ, DRAIN} state_t;

    state_t        state;
    logic [AW-1:0] last_row;
    logic [AW-1:0] row;
    logic [CW-1:0] drain_cnt;
    logic          handshake;

    // A zero or oversized length means "the whole buffer".
    function automatic logic [AW-1:0] sat_len(input logic [AW-1:0] cfg);
        if (cfg == '0 || int'(cfg) > DEPTH)
            return AW'(DEPTH);
        return cfg;
    endfunction

    assign handshake = w_valid_i & w_ready_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            last_row       <= '0;
            row            <= '0;
            drain_cnt      <= '0;
            w_ready_o      <= 1'b0;
            buf_wren_o     <= 1'b0;
            buf_wrptr_o    <= '0;
            buf_rden_o     <= 1'b0;
            buf_rdptr_o    <= '0;
            buf_clr_n_o    <= 1'b1;
            col0_valid_o   <= 1'b0;
            busy_o         <= 1'b0;
            loaded_o       <= 1'b0;
            load_done_o    <= 1'b0;
            compute_done_o <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            buf_wren_o     <= 1'b0;
            buf_clr_n_o    <= 1'b1;
            load_done_o    <= 1'b0;
            compute_done_o <= 1'b0;
            err_o          <= 1'b0;
            // Column 0 sees its read data one cycle after the read enable.
            col0_valid_o   <= buf_rden_o;

            if (abort_i) begin
                state      <= IDLE;
                busy_o     <= 1'b0;
                w_ready_o  <= 1'b0;
                buf_rden_o <= 1'b0;
                if (state == CLEAR || state == LOAD)
                    loaded_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (load_start_i) begin
                            state       <= CLEAR;
                            last_row    <= sat_len(cfg_len_i) - AW'(1);
                            loaded_o    <= 1'b0;
                            busy_o      <= 1'b1;
                            buf_clr_n_o <= 1'b0;
                            row         <= '0;
                            buf_wrptr_o <= '0;
                        end else if (compute_start_i) begin
                            if (loaded_o) begin
                                state       <= READ;
                                last_row    <= sat_len(cfg_len_i) - AW'(1);
                                busy_o      <= 1'b1;
                                buf_rden_o  <= 1'b1;
                                buf_rdptr_o <= '0;
                                buf_wrptr_o <= '0;
                            end else begin
                                err_o <= 1'b1;
                            end
                        end
                    end

                    CLEAR: begin
                        state     <= LOAD;
                        w_ready_o <= 1'b1;
                    end

                    LOAD: begin
                        if (handshake) begin
                            buf_wren_o  <= 1'b1;
                            buf_wrptr_o <= row;
                            row         <= row + AW'(1);
                            if (row == last_row) begin
                                state       <= IDLE;
                                w_ready_o   <= 1'b0;
                                busy_o      <= 1'b0;
                                loaded_o    <= 1'b1;
                                load_done_o <= 1'b1;
                            end
                        end
                    end

                    READ: begin
                        if (buf_rdptr_o == last_row) begin
                            state      <= DRAIN;
                            buf_rden_o <= 1'b0;
                            drain_cnt  <= '0;
                        end else begin
                            buf_rdptr_o <= buf_rdptr_o + AW'(1);
                        end
                    end

                    // Wait for the skew chain so the last column emits its final row.
                    DRAIN: begin
                        if (drain_cnt == CW'(COLS - 1)) begin
                            state          <= IDLE;
                            busy_o         <= 1'b0;
                            compute_done_o <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + CW'(1);
                        end
                    end

                    default: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fc_weight_ctrl.sv
// Directed testbench for fc_weight_ctrl: load, replay, errors, aborts and reset.
module tb_fc_weight_ctrl;

    localparam int DEPTH = 84;
    localparam int COLS  = 128;
    localparam int AW    = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] cfg_len = '0;
    logic          load_start = 1'b0;
    logic          compute_start = 1'b0;
    logic          abort_s = 1'b0;
    logic          w_valid = 1'b0;
    logic          w_ready_o, buf_wren_o, buf_rden_o, buf_clr_n_o, col0_valid_o;
    logic          busy_o, loaded_o, load_done_o, compute_done_o, err_o;
    logic [AW-1:0] buf_wrptr_o, buf_rdptr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fc_weight_ctrl #(.DEPTH(DEPTH), .COLS(COLS), .AW(AW)) dut (
        .clk(clk), .rst(rst), .cfg_len_i(cfg_len),
        .load_start_i(load_start), .compute_start_i(compute_start),
        .abort_i(abort_s), .w_valid_i(w_valid), .w_ready_o(w_ready_o),
        .buf_wren_o(buf_wren_o), .buf_wrptr_o(buf_wrptr_o),
        .buf_rden_o(buf_rden_o), .buf_rdptr_o(buf_rdptr_o),
        .buf_clr_n_o(buf_clr_n_o), .col0_valid_o(col0_valid_o),
        .busy_o(busy_o), .loaded_o(loaded_o), .load_done_o(load_done_o),
        .compute_done_o(compute_done_o), .err_o(err_o)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Start edge is T; the next negedge lies in cycle n=1.
    task automatic start_cmd(input logic ld, input logic cp, input logic [AW-1:0] len);
        @(negedge clk);
        cfg_len = len;
        load_start = ld;
        compute_start = cp;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        compute_start = 1'b0;
    endtask

    task automatic test_reset();
        logic [23:0] got, exp;
        exp = {1'b0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 6'b000000};
        rst = 1'b1;
        @(negedge clk);
        got = {w_ready_o, buf_wren_o, buf_wrptr_o, buf_rden_o, buf_rdptr_o, buf_clr_n_o,
               col0_valid_o, busy_o, loaded_o, load_done_o, compute_done_o, err_o};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_values got %h exp %h", got, exp);
        end
        rst = 1'b0;
        @(negedge clk);
        got = {w_ready_o, buf_wren_o, buf_wrptr_o, buf_rden_o, buf_rdptr_o, buf_clr_n_o,
               col0_valid_o, busy_o, loaded_o, load_done_o, compute_done_o, err_o};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL idle_after_reset got %h exp %h", got, exp);
        end
    endtask

    task automatic test_err_no_load();
        start_cmd(1'b0, 1'b1, AW'(5));
        @(negedge clk);
        checks++;
        if ({err_o, buf_rden_o, busy_o} !== 3'b100) begin
            errors++;
            $display("FAIL err_pulse err/rden/busy got %b exp 100", {err_o, buf_rden_o, busy_o});
        end
        @(negedge clk);
        checks++;
        if ({err_o, buf_rden_o, busy_o} !== 3'b000) begin
            errors++;
            $display("FAIL err_one_cycle err/rden/busy got %b exp 000", {err_o, buf_rden_o, busy_o});
        end
    endtask

    task automatic test_load_full(input logic [AW-1:0] cfg, input int len);
        logic [4:0] got, exp;
        w_valid = 1'b1;
        start_cmd(1'b1, 1'b0, cfg);
        for (int n = 1; n <= len + 4; n++) begin
            @(negedge clk);
            exp = {(n >= 2 && n <= len + 1), (n >= 3 && n <= len + 2), (n != 1),
                   (n == len + 2), (n <= len + 1)};
            got = {w_ready_o, buf_wren_o, buf_clr_n_o, load_done_o, busy_o};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL load cfg=%0d n=%0d ready/wren/clr_n/done/busy got %b exp %b",
                         cfg, n, got, exp);
            end
            if (n >= 3 && n <= len + 2) begin
                checks++;
                if (buf_wrptr_o !== AW'(n - 3)) begin
                    errors++;
                    $display("FAIL load_wrptr n=%0d got %0d exp %0d", n, buf_wrptr_o, n - 3);
                end
            end
        end
        w_valid = 1'b0;
        checks++;
        if (loaded_o !== 1'b1) begin
            errors++;
            $display("FAIL load_loaded got %b exp 1", loaded_o);
        end
    endtask

    task automatic test_load_bubbles();
        logic [4:0] got, exp;
        logic       ewr;
        w_valid = 1'b0;
        start_cmd(1'b1, 1'b0, AW'(4));
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            ewr = (n == 3 || n == 5 || n == 7 || n == 9);
            exp = {(n >= 2 && n <= 8), ewr, (n != 1), (n == 9), (n <= 8)};
            got = {w_ready_o, buf_wren_o, buf_clr_n_o, load_done_o, busy_o};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL bubble n=%0d ready/wren/clr_n/done/busy got %b exp %b", n, got, exp);
            end
            if (ewr) begin
                checks++;
                if (buf_wrptr_o !== AW'((n - 3) / 2)) begin
                    errors++;
                    $display("FAIL bubble_wrptr n=%0d got %0d exp %0d", n, buf_wrptr_o, (n - 3) / 2);
                end
            end
            w_valid = (n % 2 == 0);
        end
        w_valid = 1'b0;
        checks++;
        if (loaded_o !== 1'b1) begin
            errors++;
            $display("FAIL bubble_loaded got %b exp 1", loaded_o);
        end
    endtask

    task automatic test_compute(input logic [AW-1:0] cfg, input int len);
        logic [5:0] got, exp;
        start_cmd(1'b0, 1'b1, cfg);
        for (int n = 1; n <= len + COLS + 3; n++) begin
            @(negedge clk);
            exp = {(n <= len), (n >= 2 && n <= len + 1), (n == len + COLS + 1),
                   (n <= len + COLS), 1'b0, 1'b0};
            got = {buf_rden_o, col0_valid_o, compute_done_o, busy_o, buf_wren_o, err_o};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL compute cfg=%0d n=%0d rden/col0/done/busy/wren/err got %b exp %b",
                         cfg, n, got, exp);
            end
            if (n <= len) begin
                checks++;
                if (buf_rdptr_o !== AW'(n - 1) || buf_wrptr_o !== '0) begin
                    errors++;
                    $display("FAIL compute_ptr n=%0d rdptr got %0d exp %0d wrptr got %0d exp 0",
                             n, buf_rdptr_o, n - 1, buf_wrptr_o);
                end
            end
        end
        checks++;
        if (loaded_o !== 1'b1) begin
            errors++;
            $display("FAIL compute_loaded got %b exp 1", loaded_o);
        end
    endtask

    task automatic test_both_starts();
        int seen;
        seen = -1;
        w_valid = 1'b1;
        start_cmd(1'b1, 1'b1, AW'(3));
        @(negedge clk);
        checks++;
        if ({buf_clr_n_o, buf_rden_o, busy_o, loaded_o, err_o} !== 5'b00100) begin
            errors++;
            $display("FAIL both_starts clr_n/rden/busy/loaded/err got %b exp 00100",
                     {buf_clr_n_o, buf_rden_o, busy_o, loaded_o, err_o});
        end
        for (int n = 2; n <= 20; n++) begin
            @(negedge clk);
            if (load_done_o === 1'b1 && seen < 0) seen = n;
        end
        w_valid = 1'b0;
        checks++;
        if (seen != 5) begin
            errors++;
            $display("FAIL both_starts_done cycle got %0d exp 5", seen);
        end
    endtask

    task automatic test_abort_load();
        logic bad;
        bad = 1'b0;
        w_valid = 1'b1;
        start_cmd(1'b1, 1'b0, AW'(84));
        for (int n = 1; n <= 11; n++) @(negedge clk);
        checks++;
        if ({w_ready_o, buf_wren_o} !== 2'b11 || buf_wrptr_o !== AW'(8)) begin
            errors++;
            $display("FAIL abort_load_pre ready/wren got %b exp 11 wrptr got %0d exp 8",
                     {w_ready_o, buf_wren_o}, buf_wrptr_o);
        end
        abort_s = 1'b1;
        @(negedge clk);
        abort_s = 1'b0;
        checks++;
        if ({busy_o, w_ready_o, buf_wren_o, loaded_o, load_done_o} !== 5'b00000) begin
            errors++;
            $display("FAIL abort_load busy/ready/wren/loaded/done got %b exp 00000",
                     {busy_o, w_ready_o, buf_wren_o, loaded_o, load_done_o});
        end
        for (int n = 13; n <= 20; n++) begin
            @(negedge clk);
            if (load_done_o !== 1'b0 || busy_o !== 1'b0 || buf_wren_o !== 1'b0) bad = 1'b1;
        end
        w_valid = 1'b0;
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL abort_load_quiet activity got %b exp 0", bad);
        end
        start_cmd(1'b0, 1'b1, AW'(84));
        @(negedge clk);
        checks++;
        if ({err_o, buf_rden_o} !== 2'b10) begin
            errors++;
            $display("FAIL abort_load_err err/rden got %b exp 10", {err_o, buf_rden_o});
        end
    endtask

    task automatic test_abort_drain();
        logic bad;
        bad = 1'b0;
        start_cmd(1'b0, 1'b1, AW'(84));
        for (int n = 1; n <= 149; n++) @(negedge clk);
        checks++;
        if ({busy_o, buf_rden_o} !== 2'b10) begin
            errors++;
            $display("FAIL abort_drain_pre busy/rden got %b exp 10", {busy_o, buf_rden_o});
        end
        abort_s = 1'b1;
        @(negedge clk);
        abort_s = 1'b0;
        checks++;
        if ({busy_o, buf_rden_o, compute_done_o, loaded_o} !== 4'b0001) begin
            errors++;
            $display("FAIL abort_drain busy/rden/done/loaded got %b exp 0001",
                     {busy_o, buf_rden_o, compute_done_o, loaded_o});
        end
        for (int n = 151; n <= 230; n++) begin
            @(negedge clk);
            if (compute_done_o !== 1'b0 || busy_o !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL abort_drain_no_done activity got %b exp 0", bad);
        end
    endtask

    task automatic test_rst_mid_read();
        start_cmd(1'b0, 1'b1, AW'(84));
        for (int n = 1; n <= 20; n++) @(negedge clk);
        checks++;
        if ({buf_rden_o, busy_o, loaded_o} !== 3'b111) begin
            errors++;
            $display("FAIL rst_pre rden/busy/loaded got %b exp 111", {buf_rden_o, busy_o, loaded_o});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({buf_rden_o, busy_o, loaded_o, buf_clr_n_o, col0_valid_o} !== 5'b00010 ||
            buf_rdptr_o !== '0) begin
            errors++;
            $display("FAIL rst_async rden/busy/loaded/clr_n/col0 got %b exp 00010 rdptr got %0d exp 0",
                     {buf_rden_o, busy_o, loaded_o, buf_clr_n_o, col0_valid_o}, buf_rdptr_o);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({buf_rden_o, busy_o, loaded_o} !== 3'b000) begin
            errors++;
            $display("FAIL rst_release rden/busy/loaded got %b exp 000", {buf_rden_o, busy_o, loaded_o});
        end
    endtask

    initial begin
        test_reset();
        test_err_no_load();
        test_load_full(AW'(84), 84);
        test_compute(AW'(84), 84);
        test_compute(AW'(84), 84);
        test_load_bubbles();
        test_compute(AW'(4), 4);
        test_load_full(AW'(0), 84);
        test_load_full(AW'(100), 84);
        test_compute(AW'(0), 84);
        test_both_starts();
        test_abort_drain();
        test_abort_load();
        test_load_full(AW'(84), 84);
        test_rst_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_weight_ctrl.md
# fc_weight_ctrl

Sequencer for the fully-connected layer's 128-column weight buffer. Controls the buffer's write enable, write pointer, read enable, read pointer and clear strobe. Accepts a stream of weight rows (one row = 128 weights, written to all columns at once), then on command replays rows 0..len-1 into the skewed column read chain. Signals completion once the last column has emitted its final weight. Sits between the layer-level FC controller and the weight buffer; it does not touch weight data.

## Interface
- DEPTH, 84, rows per column RAM
- COLS, 128, columns in the buffer (skew length COLS-1)
- AW, 7, pointer width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_len_i  in  AW  rows to load/replay; sampled on an accepted start
- load_start_i  in  1  begin a load (clear, then write rows)
- compute_start_i  in  1  begin a replay of loaded rows
- abort_i  in  1  return to IDLE immediately
- w_valid_i  in  1  a weight row is present on the buffer's data input
- w_ready_o  out  1  row accepted this cycle when w_valid_i & w_ready_o
- buf_wren_o  out  1  buffer write enable
- buf_wrptr_o  out  AW  write row address, replicated to all columns outside this block
- buf_rden_o  out  1  column-0 read enable; the buffer skews it internally
- buf_rdptr_o  out  AW  column-0 read row address
- buf_clr_n_o  out  1  active-low buffer clear strobe
- col0_valid_o  out  1  weight_o[0] valid (buf_rden_o delayed 1 cycle)
- busy_o  out  1  state != IDLE
- loaded_o  out  1  buffer holds a complete weight set
- load_done_o  out  1  one-cycle pulse, last row written
- compute_done_o  out  1  one-cycle pulse, last column's last weight valid
- err_o  out  1  one-cycle pulse, compute_start while loaded_o=0

## Operation
- States: IDLE, CLEAR, LOAD, READ, DRAIN.
- Latched length L = cfg_len_i. Values 0 or >DEPTH saturate to DEPTH.
- IDLE:
  - load_start_i → CLEAR, latch L, clear loaded_o.
  - Else compute_start_i with loaded_o=1 → READ, latch L.
  - Else compute_start_i with loaded_o=0 → err_o pulse, stay in IDLE.
  - load_start_i wins if both starts are asserted in the same cycle.
- CLEAR: buf_clr_n_o=0 for exactly one cycle, then LOAD. Write pointer reset to 0.
- LOAD:
  - w_ready_o=1.
  - Each handshake: buf_wren_o=1, buf_wrptr_o=current row, then row+1.
  - w_valid_i low inserts bubbles; buf_wren_o=0 on those cycles.
  - On handshake of row L-1: load_done_o pulses the next cycle, loaded_o=1, → IDLE.
- READ:
  - buf_rden_o=1 for exactly L consecutive cycles; buf_rdptr_o=0,1,..,L-1.
  - buf_wren_o=0 and buf_wrptr_o=0 throughout.
  - Then → DRAIN.
- DRAIN: counter runs COLS cycles with buf_rden_o=0, then compute_done_o pulses and → IDLE. loaded_o stays 1, so replay is repeatable.
- abort_i (any state, highest priority): next cycle IDLE; wren/rden/w_ready deasserted; no done pulses. Abort during CLEAR or LOAD leaves loaded_o=0. Abort during READ or DRAIN keeps loaded_o. Start inputs are ignored in the abort cycle.
- Start inputs outside IDLE are ignored (no err_o).

## Timing
- Reset values: w_ready_o=0, buf_wren_o=0, buf_wrptr_o=0, buf_rden_o=0, buf_rdptr_o=0, buf_clr_n_o=1, col0_valid_o=0, busy_o=0, loaded_o=0, all pulses 0. State IDLE.
- All outputs are registered.
- Load started at edge T:
  - CLEAR during cycle T+1.
  - First possible write at T+2.
  - With w_valid_i held high, load_done_o at T+2+L.
- Compute started at edge T:
  - buf_rden_o high for cycles T+1..T+L.
  - col0_valid_o high for T+2..T+L+1.
  - Column COLS-1 reads row L-1 at T+L+COLS-1; data is valid at T+L+COLS.
  - compute_done_o at cycle T+L+COLS+1; busy_o falls in the same cycle.
- Asynchronous rst mid-operation: all outputs return to reset values immediately, loaded_o=0.

## Test plan
- Reset, then load L=84 with w_valid_i constant: one clear cycle, wrptr 0..83 on 84 consecutive wren cycles, load_done_o 86 cycles after start, loaded_o=1.
- Load L=4 with w_valid_i toggling every other cycle: wren only on handshakes, wrptr 0,1,2,3, load_done_o one cycle after the 4th handshake.
- Compute with L=84 after load: rden high for 84 cycles with rdptr 0..83, col0_valid_o lagging by 1, compute_done_o exactly 213 cycles after start; second compute without reload repeats identically.
- compute_start_i before any load → err_o pulse, no rden. load_start_i and compute_start_i in the same cycle → CLEAR taken. cfg_len_i=0 or 100 → 84 rows.
- abort_i at 10th row of LOAD → IDLE next cycle, loaded_o=0, no load_done_o. abort_i during DRAIN → no compute_done_o, loaded_o=1.
- Assert rst asynchronously mid-READ → rden, busy_o, loaded_o drop immediately, buf_clr_n_o=1.
